// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_seq
//  Description : Sequential IEEE-754 single-precision divider. Special
//                operands (NaN, infinity, zero, subnormal-as-zero) are
//                resolved in the accept cycle and reported one cycle later.
//                Finite normal operands run a 26-step restoring division
//                on the significands, followed by a one-cycle
//                normalise/pack step.
//
//  Ports       : clk_i       - clock, all state updates on rising edge
//                resetn_i    - synchronous active-low reset
//                start_i     - request, accepted only while idle
//                rs1_i       - dividend, raw IEEE-754 single
//                rs1Exp_i    - dividend unbiased exponent (signed)
//                rs1Sig_i    - dividend significand, hidden bit at [23]
//                rs1Class_i  - dividend one-hot class
//                              {qNaN, sNaN, inf, normal, subnormal, zero}
//                rs2_*       - divisor, same encoding as rs1_*
//                fdivOut_o   - quotient, IEEE-754 single
//                busy_o      - high whenever the unit is not idle
//                done_o      - one-cycle pulse, fdivOut_o valid
//                divZero_o   - finite nonzero divided by zero
//
//  Options     : FDIV_RNE_EN - when defined, round to nearest even;
//                              otherwise the quotient is truncated.
//                              Latency is identical in both builds.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fdiv_seq (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               start_i,
    input  logic [31:0]        rs1_i,
    input  logic signed [9:0]  rs1Exp_i,
    input  logic [23:0]        rs1Sig_i,
    input  logic [5:0]         rs1Class_i,
    input  logic [31:0]        rs2_i,
    input  logic signed [9:0]  rs2Exp_i,
    input  logic [23:0]        rs2Sig_i,
    input  logic [5:0]         rs2Class_i,
    output logic [31:0]        fdivOut_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               divZero_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_PACK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0]         c_DIV_LAST = 5'd25;   // 26 quotient bits
    localparam logic signed [10:0] c_BIAS     = 11'sd127;
    localparam logic signed [10:0] c_EXP_MIN  = -11'sd126;
    localparam logic signed [10:0] c_EXP_MAX  = 11'sd127;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic               r_sign;
    logic signed [10:0] r_exp1;
    logic signed [10:0] r_exp2;
    logic [23:0]        r_divisor;
    logic [24:0]        r_rem;
    logic [25:0]        r_quot;
    logic [4:0]         r_cnt;
    logic [31:0]        r_fdiv_out;
    logic               r_div_zero;

    // ------------------------------------------------------------------------
    // Operand classification at accept time
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic        w_sign_in;
    logic        w_zero1;
    logic        w_zero2;
    logic        w_inf1;
    logic        w_inf2;
    logic        w_special;
    logic [31:0] w_special_out;
    logic        w_special_dz;

    assign w_accept  = (r_state == S_IDLE) && start_i;
    assign w_sign_in = rs1_i[31] ^ rs2_i[31];

    // Subnormals are flushed: they behave exactly like zero.
    assign w_zero1 = rs1Class_i[0] | rs1Class_i[1];
    assign w_zero2 = rs2Class_i[0] | rs2Class_i[1];
    assign w_inf1  = rs1Class_i[3];
    assign w_inf2  = rs2Class_i[3];

    // Only normal/normal takes the iterative path.
    assign w_special = ~(rs1Class_i[2] & rs2Class_i[2]);

    always_comb begin
        w_special_out = 32'h0000_0000;
        w_special_dz  = 1'b0;
        if (rs1Class_i[5] | rs2Class_i[5]) begin
            w_special_out = rs1Class_i[5] ? rs1_i : rs2_i;
        end else if (rs1Class_i[4] | rs2Class_i[4]) begin
            w_special_out = rs1Class_i[4] ? rs1_i : rs2_i;
        end else if ((w_inf1 & w_inf2) | (w_zero1 & w_zero2)) begin
            w_special_out = {w_sign_in, 8'hFF, 1'b1, 22'd0};
        end else if (w_inf1) begin
            w_special_out = {w_sign_in, 8'hFF, 23'd0};
        end else if (w_inf2 | w_zero1) begin
            w_special_out = {w_sign_in, 31'd0};
        end else begin
            // Remaining case: finite nonzero divided by zero.
            w_special_out = {w_sign_in, 8'hFF, 23'd0};
            w_special_dz  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Restoring division step
    // ------------------------------------------------------------------------
    logic        w_qbit;
    logic [24:0] w_rem_sel;
    logic [24:0] w_rem_next;

    // The remainder stays below twice the divisor, so 25 bits never overflow
    // and the left shift never drops a set bit.
    assign w_qbit     = (r_rem >= {1'b0, r_divisor});
    assign w_rem_sel  = w_qbit ? (r_rem - {1'b0, r_divisor}) : r_rem;
    assign w_rem_next = w_rem_sel << 1;

    // ------------------------------------------------------------------------
    // Normalise, round and pack
    // ------------------------------------------------------------------------
    logic               w_q_hi;
    logic [22:0]        w_frac_raw;
    logic signed [10:0] w_exp_base;
    logic signed [10:0] w_exp_fin;
    logic [22:0]        w_frac_fin;
    logic [7:0]         w_exp_field;
    logic [31:0]        w_pack_out;

    // Operand significands are both in [1,2), so the ratio lies in (1/2,2):
    // either q[25] or q[24] is the leading one.
    assign w_q_hi     = r_quot[25];
    assign w_frac_raw = w_q_hi ? r_quot[24:2] : r_quot[23:1];
    assign w_exp_base = r_exp1 - r_exp2 - (w_q_hi ? 11'sd0 : 11'sd1);

`ifdef FDIV_RNE_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_frac_inc;

    assign w_guard    = w_q_hi ? r_quot[1] : r_quot[0];
    assign w_sticky   = (w_q_hi & r_quot[0]) | (r_rem != 25'd0);
    assign w_round_up = w_guard & (w_sticky | w_frac_raw[0]);
    assign w_frac_inc = {1'b0, w_frac_raw} + {23'd0, w_round_up};

    // The hidden bit is always set, so a carry out of the fraction means the
    // significand reached 2^24: renormalise to 1.0 and bump the exponent.
    always_comb begin
        w_frac_fin = w_frac_inc[22:0];
        w_exp_fin  = w_exp_base;
        if (w_frac_inc[23]) begin
            w_frac_fin = 23'd0;
            w_exp_fin  = w_exp_base + 11'sd1;
        end
    end
`else
    always_comb begin
        w_frac_fin = w_frac_raw;
        w_exp_fin  = w_exp_base;
    end
`endif

    assign w_exp_field = 8'(w_exp_fin + c_BIAS);

    always_comb begin
        w_pack_out = {r_sign, w_exp_field, w_frac_fin};
        if (w_exp_fin < c_EXP_MIN) begin
            w_pack_out = {r_sign, 31'd0};
        end else if (w_exp_fin > c_EXP_MAX) begin
            w_pack_out = {r_sign, 8'hFF, 23'd0};
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = w_special ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state_next = S_PACK;
                end
            end
            S_PACK:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy_o = (r_state != S_IDLE);
        done_o = (r_state == S_DONE);
    end

    assign fdivOut_o = r_fdiv_out;
    assign divZero_o = r_div_zero;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_sign     <= 1'b0;
            r_exp1     <= 11'sd0;
            r_exp2     <= 11'sd0;
            r_divisor  <= 24'd0;
            r_rem      <= 25'd0;
            r_quot     <= 26'd0;
            r_cnt      <= 5'd0;
            r_fdiv_out <= 32'd0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign    <= w_sign_in;
                r_exp1    <= {rs1Exp_i[9], rs1Exp_i};
                r_exp2    <= {rs2Exp_i[9], rs2Exp_i};
                r_divisor <= rs2Sig_i;
                r_rem     <= {1'b0, rs1Sig_i};
                r_quot    <= 26'd0;
                r_cnt     <= 5'd0;
                if (w_special) begin
                    r_fdiv_out <= w_special_out;
                    r_div_zero <= w_special_dz;
                end else begin
                    r_div_zero <= 1'b0;
                end
            end else if (r_state == S_DIV) begin
                r_quot <= {r_quot[24:0], w_qbit};
                r_rem  <= w_rem_next;
                r_cnt  <= r_cnt + 5'd1;
            end else if (r_state == S_PACK) begin
                r_fdiv_out <= w_pack_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdiv_seq
//  Description : Directed self-checking bench for fdiv_seq. Operand
//                exponent/significand/class fields are derived from the raw
//                IEEE-754 words; expected quotients are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fdiv_seq;

    logic               clk_i;
    logic               resetn_i;
    logic               start_i;
    logic [31:0]        rs1_i;
    logic signed [9:0]  rs1Exp_i;
    logic [23:0]        rs1Sig_i;
    logic [5:0]         rs1Class_i;
    logic [31:0]        rs2_i;
    logic signed [9:0]  rs2Exp_i;
    logic [23:0]        rs2Sig_i;
    logic [5:0]         rs2Class_i;
    logic [31:0]        fdivOut_o;
    logic               busy_o;
    logic               done_o;
    logic               divZero_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FDIV_RNE_EN
    localparam logic [31:0] c_ONE_THIRD = 32'h3EAA_AAAB;
    localparam logic [31:0] c_TWO_THIRD = 32'h3F2A_AAAB;
`else
    localparam logic [31:0] c_ONE_THIRD = 32'h3EAA_AAAA;
    localparam logic [31:0] c_TWO_THIRD = 32'h3F2A_AAAA;
`endif

    fdiv_seq u_dut (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .start_i    (start_i),
        .rs1_i      (rs1_i),
        .rs1Exp_i   (rs1Exp_i),
        .rs1Sig_i   (rs1Sig_i),
        .rs1Class_i (rs1Class_i),
        .rs2_i      (rs2_i),
        .rs2Exp_i   (rs2Exp_i),
        .rs2Sig_i   (rs2Sig_i),
        .rs2Class_i (rs2Class_i),
        .fdivOut_o  (fdivOut_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .divZero_o  (divZero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------------
    // Operand field decoding from raw words
    // ------------------------------------------------------------------------
    function automatic logic [5:0] f_cls(input logic [31:0] f);
        logic [7:0]  e;
        logic [22:0] m;
        e = f[30:23];
        m = f[22:0];
        if (e == 8'd0)        return (m == 23'd0) ? 6'b000001 : 6'b000010;
        else if (e == 8'hFF) begin
            if (m == 23'd0)   return 6'b001000;
            else if (m[22])   return 6'b100000;
            else              return 6'b010000;
        end
        return 6'b000100;
    endfunction

    function automatic logic signed [9:0] f_exp(input logic [31:0] f);
        int x;
        if (f[30:23] == 8'd0 || f[30:23] == 8'hFF) return 10'sd0;
        x = int'(f[30:23]) - 127;
        return x[9:0];
    endfunction

    function automatic logic [23:0] f_sig(input logic [31:0] f);
        if (f[30:23] == 8'd0 || f[30:23] == 8'hFF) return 24'd0;
        return {1'b1, f[22:0]};
    endfunction

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        rs1_i      = a;
        rs1Exp_i   = f_exp(a);
        rs1Sig_i   = f_sig(a);
        rs1Class_i = f_cls(a);
        rs2_i      = b;
        rs2Exp_i   = f_exp(b);
        rs2Sig_i   = f_sig(b);
        rs2Class_i = f_cls(b);
    endtask

    // Runs one operation starting at a negedge with the unit idle. Operands
    // are scrambled right after accept. Returns the result, the cycle count
    // from accept to done_o (-1 on timeout) and whether busy_o stayed high;
    // ends at the first negedge after the done cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic dz, output logic busy_ok);
        set_ops(a, b);
        start_i = 1'b1;
        busy_ok = 1'b1;
        lat     = -1;
        res     = 32'd0;
        dz      = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        set_ops(32'h4110_0000, 32'h3F00_0000);
        for (int k = 1; k <= 40; k++) begin
            if (!busy_o) busy_ok = 1'b0;
            if (done_o) begin
                lat = k;
                res = fdivOut_o;
                dz  = divZero_o;
                break;
            end
            @(negedge clk_i);
        end
        @(negedge clk_i);
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        resetn_i = 1'b0;
        start_i  = 1'b0;
        set_ops(32'h0, 32'h0);
        repeat (3) @(negedge clk_i);
        n_checks++; if (fdivOut_o !== 32'd0) begin n_errors++; $display("FAIL reset_out: got %h want 00000000", fdivOut_o); end
        n_checks++; if (busy_o !== 1'b0)     begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0)     begin n_errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_checks++; if (divZero_o !== 1'b0)  begin n_errors++; $display("FAIL reset_dz: got %b want 0", divZero_o); end
        resetn_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_normal();
        logic [31:0] res;
        int          lat;
        logic        dz;
        logic        bok;
        do_op(32'h40C0_0000, 32'h4000_0000, res, lat, dz, bok);
        n_checks++; if (res !== 32'h4040_0000) begin n_errors++; $display("FAIL six_by_two: got %h want 40400000", res); end
        n_checks++; if (lat != 28)             begin n_errors++; $display("FAIL six_by_two_latency: got %0d want 28", lat); end
        n_checks++; if (bok !== 1'b1)          begin n_errors++; $display("FAIL six_by_two_busy: got %b want 1", bok); end
        n_checks++; if (dz !== 1'b0)           begin n_errors++; $display("FAIL six_by_two_dz: got %b want 0", dz); end
        // One cycle after done: idle, pulse gone, result held.
        n_checks++; if (done_o !== 1'b0)       begin n_errors++; $display("FAIL done_pulse: got %b want 0", done_o); end
        n_checks++; if (busy_o !== 1'b0)       begin n_errors++; $display("FAIL idle_busy: got %b want 0", busy_o); end
        repeat (3) @(negedge clk_i);
        n_checks++; if (fdivOut_o !== 32'h4040_0000) begin n_errors++; $display("FAIL result_hold: got %h want 40400000", fdivOut_o); end

        do_op(32'h4040_0000, 32'h4000_0000, res, lat, dz, bok);
        n_checks++; if (res !== 32'h3FC0_0000) begin n_errors++; $display("FAIL three_by_two: got %h want 3FC00000", res); end
        do_op(32'hBF80_0000, 32'h4080_0000, res, lat, dz, bok);
        n_checks++; if (res !== 32'hBE80_0000) begin n_errors++; $display("FAIL neg_quarter: got %h want BE800000", res); end
        n_checks++; if (lat != 28)             begin n_errors++; $display("FAIL neg_quarter_latency: got %0d want 28", lat); end
    endtask

    task automatic test_rounding();
        logic [31:0] res;
        int          lat;
        logic        dz;
        logic        bok;
        do_op(32'h3F80_0000, 32'h4040_0000, res, lat, dz, bok);
        n_checks++; if (res !== c_ONE_THIRD) begin n_errors++; $display("FAIL one_third: got %h want %h", res, c_ONE_THIRD); end
        n_checks++; if (lat != 28)           begin n_errors++; $display("FAIL one_third_latency: got %0d want 28", lat); end
        do_op(32'h4000_0000, 32'h4040_0000, res, lat, dz, bok);
        n_checks++; if (res !== c_TWO_THIRD) begin n_errors++; $display("FAIL two_thirds: got %h want %h", res, c_TWO_THIRD); end
    endtask

    task automatic test_special();
        logic [31:0] sp_a   [12] = '{32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0001, 32'h7FA0_0000,
                                     32'h7FA0_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000,
                                     32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h40A0_0000};
        logic [31:0] sp_b   [12] = '{32'h0000_0000, 32'h0000_0000, 32'h7FA0_0000, 32'h7FC1_2345,
                                     32'h3F80_0000, 32'hFF90_0000, 32'h7F80_0000, 32'h4000_0000,
                                     32'h7F80_0000, 32'h4040_0000, 32'h0000_0000, 32'h8000_0001};
        logic [31:0] sp_res [12] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0001, 32'h7FC1_2345,
                                     32'h7FA0_0000, 32'hFF90_0000, 32'hFFC0_0000, 32'hFF80_0000,
                                     32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'hFF80_0000};
        logic        sp_dz  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] res;
        int          lat;
        logic        dz;
        logic        bok;
        for (int i = 0; i < 12; i++) begin
            do_op(sp_a[i], sp_b[i], res, lat, dz, bok);
            n_checks++; if (res !== sp_res[i]) begin n_errors++; $display("FAIL special[%0d]_result: got %h want %h", i, res, sp_res[i]); end
            n_checks++; if (dz !== sp_dz[i])   begin n_errors++; $display("FAIL special[%0d]_dz: got %b want %b", i, dz, sp_dz[i]); end
            n_checks++; if (lat != 1)          begin n_errors++; $display("FAIL special[%0d]_latency: got %0d want 1", i, lat); end
        end
        // divZero_o and the result stay put while idle.
        do_op(32'h3F80_0000, 32'h0000_0000, res, lat, dz, bok);
        repeat (4) @(negedge clk_i);
        n_checks++; if (divZero_o !== 1'b1)           begin n_errors++; $display("FAIL dz_hold: got %b want 1", divZero_o); end
        n_checks++; if (fdivOut_o !== 32'h7F80_0000)  begin n_errors++; $display("FAIL dz_result_hold: got %h want 7F800000", fdivOut_o); end
    endtask

    task automatic test_range();
        logic [31:0] res;
        int          lat;
        logic        dz;
        logic        bok;
        do_op(32'h7F00_0000, 32'h3E80_0000, res, lat, dz, bok);
        n_checks++; if (res !== 32'h7F80_0000) begin n_errors++; $display("FAIL overflow: got %h want 7F800000", res); end
        n_checks++; if (lat != 28)             begin n_errors++; $display("FAIL overflow_latency: got %0d want 28", lat); end
        n_checks++; if (dz !== 1'b0)           begin n_errors++; $display("FAIL overflow_dz: got %b want 0", dz); end
        do_op(32'h0080_0000, 32'h4000_0000, res, lat, dz, bok);
        n_checks++; if (res !== 32'h0000_0000) begin n_errors++; $display("FAIL underflow: got %h want 00000000", res); end
        n_checks++; if (lat != 28)             begin n_errors++; $display("FAIL underflow_latency: got %0d want 28", lat); end
    endtask

    task automatic test_start_ignored();
        int          lat = -1;
        logic [31:0] res = 32'd0;
        set_ops(32'h40C0_0000, 32'h4000_0000);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                set_ops(32'h3F80_0000, 32'h4040_0000);
                start_i = 1'b1;
            end
            if (k == 11) start_i = 1'b0;
            if (done_o) begin
                lat = k;
                res = fdivOut_o;
                break;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (res !== 32'h4040_0000) begin n_errors++; $display("FAIL start_ignored_result: got %h want 40400000", res); end
        n_checks++; if (lat != 28)             begin n_errors++; $display("FAIL start_ignored_latency: got %0d want 28", lat); end
        n_checks++; if (busy_o !== 1'b0)       begin n_errors++; $display("FAIL start_ignored_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        dz;
        logic        bok;
        set_ops(32'h40C0_0000, 32'h4000_0000);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        resetn_i = 1'b0;
        @(negedge clk_i);
        resetn_i = 1'b1;
        n_checks++; if (busy_o !== 1'b0)     begin n_errors++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0)     begin n_errors++; $display("FAIL midreset_done: got %b want 0", done_o); end
        n_checks++; if (fdivOut_o !== 32'd0) begin n_errors++; $display("FAIL midreset_out: got %h want 00000000", fdivOut_o); end
        n_checks++; if (divZero_o !== 1'b0)  begin n_errors++; $display("FAIL midreset_dz: got %b want 0", divZero_o); end
        do_op(32'h3F80_0000, 32'h4040_0000, res, lat, dz, bok);
        n_checks++; if (res !== c_ONE_THIRD) begin n_errors++; $display("FAIL after_reset_result: got %h want %h", res, c_ONE_THIRD); end
        n_checks++; if (lat != 28)           begin n_errors++; $display("FAIL after_reset_latency: got %0d want 28", lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_special();
        test_range();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
